// File: rtl/m16_pkg.sv
// m16_pkg: definitions shared by the M16 imitator word path (M2 frame
// sequencer, filler, serializer).
//   - seq_state_e : frame sequencer FSM encoding (IDLE/ARM/RUN/DRAIN)
//   - WORD_PTR_W / GRP_W : widths of the in-frame word pointer and group counter
//   - DEF_WORDS / DEF_GROUPS / DEF_CLK_DIV : default frame geometry and slot length
//   - mod_inc : increment that wraps at an arbitrary limit
package m16_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ARM   = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_DRAIN = 2'd3
    } seq_state_e;

    localparam int WORD_PTR_W  = 8;
    localparam int GRP_W       = 5;
    localparam int DIV_W       = 10;
    localparam int DEF_WORDS   = 256;
    localparam int DEF_GROUPS  = 32;
    localparam int DEF_CLK_DIV = 48;

    // Counters wrap at their parameter limit rather than at 2**width, so a
    // frame shorter than 256 words still wraps cleanly.
    function automatic int unsigned mod_inc(input int unsigned value,
                                            input int unsigned limit);
        if (value >= (limit - 32'd1)) begin
            return 32'd0;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/m16_param_check.sv
// m16_param_check: elaboration-time guard on the frame geometry.
// No ports; instantiated by the sequencer with its own parameters.
//   CLK_DIV must lie in 3..1023 (the divider is 10 bits and a slot needs
//   at least a strobe cycle, a valid cycle and one spare cycle).
//   WORDS must lie in 2..256 and GROUPS in 2..32 to fit the counters.
module m16_param_check #(
    parameter int CLK_DIV = 48,
    parameter int WORDS   = 256,
    parameter int GROUPS  = 32
) ();

    if ((CLK_DIV < 3) || (CLK_DIV > 1023)) begin : g_bad_clk_div
        $error("m16_param_check: CLK_DIV out of range 3..1023");
    end

    if ((WORDS < 2) || (WORDS > 256)) begin : g_bad_words
        $error("m16_param_check: WORDS out of range 2..256");
    end

    if ((GROUPS < 2) || (GROUPS > 32)) begin : g_bad_groups
        $error("m16_param_check: GROUPS out of range 2..32");
    end

endmodule

// File: rtl/m16_slot_timer.sv
// m16_slot_timer: word-slot divider for the M2 frame sequencer.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset (divider -> 0)
//   clear_i    hold divider at 0 (priority over en_i)
//   en_i       advance the divider 0..CLK_DIV-1, wrapping
//   tick_o     divider == 0 (strobe cycle of the slot)
//   tick_d1_o  divider == 1 (cycle after the strobe)
module m16_slot_timer
    import m16_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o,
    output logic tick_d1_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value: clear wins, otherwise count and wrap at CLK_DIV-1.
    always_comb begin
        div_d = div_q;
        if (clear_i) begin
            div_d = '0;
        end else if (en_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Divider register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o    = (div_q == DIV_W'(0));
    assign tick_d1_o = (div_q == DIV_W'(1));

endmodule

// File: rtl/m2_frame_sequencer.sv
// m2_frame_sequencer: owns M2 frame timing for the M16 imitator word filler.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            run request (level) from mode control
//   ser_ready         serializer can take a word in this slot
//   clear_err         one-cycle pulse, clears underrun
//   bufGetWord        read strobe to the filler (first cycle of each slot)
//   bufRdPointer      word index within the frame (0..WORDS-1)
//   cntGrp            frame index within the group (0..GROUPS-1)
//   word_valid        filler output valid, one cycle after bufGetWord
//   frame_start       bufGetWord for word 0
//   group_start       bufGetWord for word 0 of frame 0
//   seq_state         FSM state (IDLE=0, ARM=1, RUN=2, DRAIN=3)
//   underrun          sticky: serializer was not ready at a strobe
module m2_frame_sequencer
    import m16_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int WORDS   = DEF_WORDS,
    parameter int GROUPS  = DEF_GROUPS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ser_ready,
    input  logic                  clear_err,
    output logic                  bufGetWord,
    output logic [WORD_PTR_W-1:0] bufRdPointer,
    output logic [GRP_W-1:0]      cntGrp,
    output logic                  word_valid,
    output logic                  frame_start,
    output logic                  group_start,
    output logic [1:0]            seq_state,
    output logic                  underrun
);

    localparam logic [WORD_PTR_W-1:0] PTR_LAST = WORD_PTR_W'(WORDS - 1);

    m16_param_check #(
        .CLK_DIV (CLK_DIV),
        .WORDS   (WORDS),
        .GROUPS  (GROUPS)
    ) u_param_check ();

    seq_state_e            state_q,    state_d;
    logic [WORD_PTR_W-1:0] ptr_q,      ptr_d;
    logic [GRP_W-1:0]      grp_q,      grp_d;
    logic                  underrun_q, underrun_d;

    logic busy_s;
    logic next_busy_s;
    logic tick_s;
    logic tick_d1_s;
    logic strobe_s;
    logic valid_s;
    logic last_word_s;

    // The divider is cleared whenever the next state is not a running one,
    // so every entry into RUN starts a slot on its very first cycle. It only
    // advances while running, which keeps it at 0 through ARM.
    m16_slot_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_slot_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (~next_busy_s),
        .en_i      (busy_s),
        .tick_o    (tick_s),
        .tick_d1_o (tick_d1_s)
    );

    // Next-state, counter and error-flag logic.
    always_comb begin
        busy_s      = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
        strobe_s    = busy_s && tick_s;
        valid_s     = busy_s && tick_d1_s;
        last_word_s = (ptr_q == PTR_LAST);
        state_d     = state_q;
        ptr_d       = ptr_q;
        grp_d       = grp_q;
        underrun_d  = underrun_q;

        case (state_q)
            SEQ_IDLE: begin
                if (enable) begin
                    state_d = SEQ_ARM;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_ARM: begin
                if (!enable) begin
                    state_d = SEQ_IDLE;
                end else if (ser_ready) begin
                    state_d = SEQ_RUN;
                end else begin
                    state_d = SEQ_ARM;
                end
            end
            SEQ_RUN: begin
                if (!enable) begin
                    state_d = SEQ_DRAIN;
                end else begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_DRAIN: begin
                // Re-enable resumes RUN without disturbing slot timing; else
                // leave once the last word of the frame has been delivered.
                if (enable) begin
                    state_d = SEQ_RUN;
                end else if (valid_s && last_word_s) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_DRAIN;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        next_busy_s = (state_d == SEQ_RUN) || (state_d == SEQ_DRAIN);

        // Counters advance in the valid cycle so they stay stable across the
        // strobe cycle and the one after it.
        if (!next_busy_s) begin
            ptr_d = '0;
            grp_d = '0;
        end else if (valid_s) begin
            ptr_d = WORD_PTR_W'(mod_inc(32'(ptr_q), WORDS));
            if (last_word_s) begin
                grp_d = GRP_W'(mod_inc(32'(grp_q), GROUPS));
            end else begin
                grp_d = grp_q;
            end
        end else begin
            ptr_d = ptr_q;
            grp_d = grp_q;
        end

        // A new underrun beats a simultaneous clear so no event is lost.
        if (strobe_s && !ser_ready) begin
            underrun_d = 1'b1;
        end else if (clear_err) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // State, counter and error-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            ptr_q      <= '0;
            grp_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grp_q      <= grp_d;
            underrun_q <= underrun_d;
        end
    end

    assign bufGetWord   = strobe_s;
    assign word_valid   = valid_s;
    assign frame_start  = strobe_s && (ptr_q == WORD_PTR_W'(0));
    assign group_start  = strobe_s && (ptr_q == WORD_PTR_W'(0)) && (grp_q == GRP_W'(0));
    assign bufRdPointer = ptr_q;
    assign cntGrp       = grp_q;
    assign seq_state    = state_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_m2_frame_sequencer.sv
// Self-checking bench for m2_frame_sequencer with CLK_DIV=4, 256 words,
// 32 groups. A cycle table covers start-up, slot timing, underrun set/clear
// and a RUN/DRAIN toggle; hand sequences cover frame/group wrap, draining to
// IDLE, reset mid-frame and an ARM stall.
module tb_m2_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       ser_ready;
    logic       clear_err;
    logic       bufGetWord;
    logic [7:0] bufRdPointer;
    logic [4:0] cntGrp;
    logic       word_valid;
    logic       frame_start;
    logic       group_start;
    logic [1:0] seq_state;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

    m2_frame_sequencer #(
        .CLK_DIV (4),
        .WORDS   (256),
        .GROUPS  (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ser_ready    (ser_ready),
        .clear_err    (clear_err),
        .bufGetWord   (bufGetWord),
        .bufRdPointer (bufRdPointer),
        .cntGrp       (cntGrp),
        .word_valid   (word_valid),
        .frame_start  (frame_start),
        .group_start  (group_start),
        .seq_state    (seq_state),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       sr;
        logic       clr;
        logic       bgw;
        logic       wv;
        logic       fs;
        logic       gs;
        logic [7:0] ptr;
        logic [4:0] grp;
        logic [1:0] st;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic sr, logic clr,
                                logic bgw, logic wv, logic fs, logic gs,
                                logic [7:0] ptr, logic [4:0] grp,
                                logic [1:0] st, logic un);
        vec_t v;
        v.rst = rst; v.en = en; v.sr = sr; v.clr = clr;
        v.bgw = bgw; v.wv = wv; v.fs = fs; v.gs = gs;
        v.ptr = ptr; v.grp = grp; v.st = st; v.un = un;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a strobe with the given pointer/group, bounded by a budget.
    task automatic run_to(input logic [7:0] p, input logic [4:0] g,
                          input int budget, input string nm);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bufGetWord && (bufRdPointer == p) && (cntGrp == g)) begin
                found = 1'b1;
                break;
            end
        end
        check(nm, 32'(found), 32'd1);
    endtask

    function automatic logic [19:0] outs_now();
        return {bufGetWord, word_valid, frame_start, group_start,
                bufRdPointer, cntGrp, seq_state, underrun};
    endfunction

    initial begin
        logic bad;
        reset = 1'b1; enable = 1'b0; ser_ready = 1'b0; clear_err = 1'b0;

        // rst en sr clr | bgw wv fs gs ptr grp st un  (outputs after the edge)
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd0,5'd0,2'd0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd0,5'd0,2'd1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1, 8'd0,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'd0,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 8'd1,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'd1,5'd0,2'd2,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd2,5'd0,2'd2,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 8'd2,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 8'd2,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0, 8'd2,5'd0,2'd2,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd3,5'd0,2'd2,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 8'd3,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 8'd3,5'd0,2'd3,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'd3,5'd0,2'd2,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd4,5'd0,2'd3,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd4,5'd0,2'd2,1'b0));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; enable = vecs[i].en;
            ser_ready = vecs[i].sr; clear_err = vecs[i].clr;
            step();
            check($sformatf("vec%0d", i), 32'(outs_now()),
                  32'({vecs[i].bgw, vecs[i].wv, vecs[i].fs, vecs[i].gs,
                       vecs[i].ptr, vecs[i].grp, vecs[i].st, vecs[i].un}));
        end
        clear_err = 1'b0; enable = 1'b1; ser_ready = 1'b1;

        // Frame wrap: 257th strobe is word 0 of frame 1.
        run_to(8'd255, 5'd0, 2000, "reach_p255_g0");
        step();
        check("valid_p255", 32'({word_valid, bufRdPointer}), 32'({1'b1, 8'd255}));
        step(); step(); step();
        check("frame_wrap", 32'({bufGetWord, frame_start, group_start, bufRdPointer, cntGrp}),
              32'({1'b1, 1'b1, 1'b0, 8'd0, 5'd1}));

        // Group wrap after 32 frames.
        run_to(8'd255, 5'd31, 40000, "reach_p255_g31");
        step(); step(); step(); step();
        check("group_wrap", 32'({bufGetWord, frame_start, group_start, bufRdPointer, cntGrp}),
              32'({1'b1, 1'b1, 1'b1, 8'd0, 5'd0}));

        // Drain from word 100 with an underrun, re-enable at 200, drain out.
        run_to(8'd100, 5'd0, 2000, "reach_p100");
        enable = 1'b0; ser_ready = 1'b0;
        step();
        check("drain_entry", 32'({seq_state, underrun, word_valid}), 32'({2'd3, 1'b1, 1'b1}));
        ser_ready = 1'b1;
        run_to(8'd200, 5'd0, 2000, "drain_reach_p200");
        check("drain_at_p200", 32'(seq_state), 32'd3);
        enable = 1'b1;
        step();
        check("reenable_run", 32'(seq_state), 32'd2);
        step(); step(); step();
        check("reenable_no_gap", 32'({bufGetWord, bufRdPointer}), 32'({1'b1, 8'd201}));
        enable = 1'b0;
        run_to(8'd255, 5'd0, 2000, "drain_reach_p255");
        check("drain_last_state", 32'(seq_state), 32'd3);
        step();
        check("drain_last_valid", 32'(word_valid), 32'd1);
        step();
        check("drain_to_idle", 32'({seq_state, bufRdPointer, cntGrp, bufGetWord, underrun}),
              32'({2'd0, 8'd0, 5'd0, 1'b0, 1'b1}));
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("clear_in_idle", 32'({seq_state, underrun}), 32'({2'd0, 1'b0}));

        // Restart, underrun at slot 10, then reset mid-frame at word 57.
        enable = 1'b1;
        step();
        check("restart_arm", 32'(seq_state), 32'd1);
        step();
        check("restart_first", 32'({bufGetWord, frame_start, group_start, bufRdPointer, cntGrp}),
              32'({1'b1, 1'b1, 1'b1, 8'd0, 5'd0}));
        run_to(8'd10, 5'd0, 200, "reach_p10");
        ser_ready = 1'b0;
        step();
        check("underrun_slot10", 32'({underrun, word_valid, bufRdPointer}), 32'({1'b1, 1'b1, 8'd10}));
        ser_ready = 1'b1;
        run_to(8'd57, 5'd0, 500, "reach_p57");
        reset = 1'b1;
        step();
        check("reset_mid_frame", 32'(outs_now()), 32'd0);
        reset = 1'b0; enable = 1'b0;
        step();

        // ARM stall: serializer never ready.
        enable = 1'b1; ser_ready = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bufGetWord || word_valid || (seq_state != 2'd1)) begin
                bad = 1'b1;
            end
        end
        check("arm_stall", 32'({bad, seq_state}), 32'({1'b0, 2'd1}));
        enable = 1'b0;
        step();
        check("arm_to_idle", 32'({seq_state, bufGetWord}), 32'({2'd0, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
